// File: rtl/mul_acc_reconstruct.sv
// Sequential shift-add multiply-accumulate: product = a*b + c in N RUN cycles.
// Also used to rebuild a dividend from quotient, divisor and remainder.
module mul_acc_reconstruct #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic [N-1:0]   c,
  output logic [2*N-1:0] product,
  output logic           busy,
  output logic           done
);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  count_q, count_d;
  logic [2*N-1:0] prod_q, prod_d;
  logic [2*N-1:0] step_sum;

  // Max result 2^2N - 2^N fits in 2N bits, so no carry-out is kept.
  assign step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    prod_d   = prod_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d    = {{N{1'b0}}, c};
          mcand_d  = {{N{1'b0}}, a};
          mplier_d = b;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = step_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        if (count_q == CW'(N - 1)) begin
          prod_d  = step_sum;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      prod_q   <= prod_d;
    end
  end

  assign product = prod_q;
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
endmodule
